// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Encoding 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor_b.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
module full_subtractor_b (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   // Borrow when b exceeds a, or when a==b and a borrow is already pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first,
// built around a single full_subtractor_b cell with a registered borrow loop.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int              CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   res_sh;
   logic [WIDTH-1:0]   res_next;
   logic               borrow;
   logic [CNT_W-1:0]   cnt;
   logic               cell_diff;
   logic               cell_bout;

   full_subtractor_b u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   // New result bit enters at the MSB so that after WIDTH shifts bit 0 lands at LSB.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_next = cell_diff;
      end else begin : g_res_wn
         assign res_next = {cell_diff, res_sh[WIDTH-1:1]};
      end
   endgenerate

   // NOTE: every register here is assigned with <= so all updates in one edge see
   // the pre-edge values; blocking = would let later lines read already-shifted data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
         ready  <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  res_sh <= '0;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  state  <= SHIFT;
                  ready  <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            SHIFT: begin
               res_sh <= res_next;
               borrow <= cell_bout;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  diff  <= res_next;
                  bout  <= cell_bout;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors plus back-to-back random pairs.
module tb_serial_subtractor;
   import serial_subtractor_pkg::*;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      int           cyc;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input bit ok, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
   endtask

   // Monitor: pops one expectation per done pulse; also checks pulse width,
   // ready after done, and that the result holds between completions.
   initial begin
      exp_t         e;
      logic [W-1:0] hold_diff = '0;
      logic         hold_bout = 1'b0;
      logic         prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_diff = '0;
            hold_bout = 1'b0;
            prev_done = 1'b0;
         end else begin
            if (prev_done)
               check("ready_after_done", ready == 1'b1, 32'(ready), 32'd1);
            if (done) begin
               check("done_width", !prev_done, 32'(prev_done), 32'd0);
               if (sb.size() == 0) begin
                  check("unexpected_done", 1'b0, 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("diff", diff == e.diff, 32'(diff), 32'(e.diff));
                  check("bout", bout == e.bout, 32'(bout), 32'(e.bout));
                  check("latency", cyc == e.cyc, 32'(cyc), 32'(e.cyc));
                  hold_diff = e.diff;
                  hold_bout = e.bout;
               end
            end else begin
               check("diff_hold", diff == hold_diff, 32'(diff), 32'(hold_diff));
               check("bout_hold", bout == hold_bout, 32'(bout), 32'(hold_bout));
            end
            prev_done = done;
         end
      end
   end

   // Waits for ready, presents one operation for a single accepting edge.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input bit push);
      int waited = 0;
      @(negedge clk);
      while (!ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!ready) begin
         check("ready_timeout", 1'b0, 32'(ready), 32'd1);
         return;
      end
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      if (push) sb.push_back('{ed, eb, cyc + W});
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           drain;

      repeat (3) @(posedge clk);
      #2;
      check("rst_ready", ready == 1'b1, 32'(ready), 32'd1);
      check("rst_busy",  busy  == 1'b0, 32'(busy),  32'd0);
      check("rst_done",  done  == 1'b0, 32'(done),  32'd0);
      check("rst_diff",  diff  == '0,   32'(diff),  32'd0);
      rst_n = 1'b1;

      issue(8'h5A, 8'h23, 8'h37, 1'b0, 1'b1);
      issue(8'h10, 8'h20, 8'hF0, 1'b1, 1'b1);
      issue(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      issue(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b1);
      issue(8'h00, 8'hFF, 8'h01, 1'b1, 1'b1);

      // Start held during SHIFT must be ignored.
      issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      check("busy_mid", busy == 1'b1, 32'(busy), 32'd1);
      check("ready_mid", ready == 1'b0, 32'(ready), 32'd0);
      a     = 8'hFF;
      b     = 8'h00;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;

      // Abort in the fourth SHIFT cycle; no expectation is queued for it.
      issue(8'h33, 8'h11, 8'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_diff", diff == '0,   32'(diff), 32'd0);
      check("abort_bout", bout == 1'b0, 32'(bout), 32'd0);
      check("abort_done", done == 1'b0, 32'(done), 32'd0);
      check("abort_busy", busy == 1'b0, 32'(busy), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("release_ready", ready == 1'b1, 32'(ready), 32'd1);
      issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

      // Back-to-back random pairs against the arithmetic model.
      for (int i = 0; i < 200; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         issue(ra, rb, ra - rb, (ra < rb), 1'b1);
      end

      drain = 0;
      while (sb.size() != 0 && drain < 50) begin
         @(negedge clk);
         drain++;
      end
      check("scoreboard_empty", sb.size() == 0, 32'(sb.size()), 32'd0);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor that computes diff = a - b, one bit per clock, LSB first.
- Built around the existing full_subtractor_b bit cell; a registered borrow feeds back into the cell's bin.
- Sits directly around that cell: sequences operand bits into it and collects diff/bout into a parallel result.
- Small-area alternative to a ripple subtractor for the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (WIDTH >= 1).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin; sampled only when ready=1.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in SHIFT only.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  registered result, a - b modulo 2^WIDTH.
- bout  output  1  final borrow: 1 iff a < b (unsigned).

Behaviour:
- Reset (async on rst_n=0):
  - state=IDLE; diff=0; bout=0; done=0.
  - Internal shift registers, borrow register and counter cleared.
  - Reset mid-operation aborts the operation: no done pulse; outputs go to 0 immediately.
- Release is synchronous to clk; the first accepted start is possible on the first rising edge with rst_n=1.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on an edge with start=1. At that edge:
    - a_sh <= a; b_sh <= b.
    - borrow <= 0; cnt <= 0; res_sh <= 0.
  - SHIFT, every edge:
    - Cell inputs: a=a_sh[0], b=b_sh[0], bin=borrow.
    - res_sh <= {cell.diff, res_sh[WIDTH-1:1]}; borrow <= cell.bout.
    - a_sh and b_sh shift right by 1; cnt <= cnt+1.
    - When cnt==WIDTH-1 at the edge: go to DONE.
    - In the same edge, diff <= the final shifted result and bout <= cell.bout.
  - DONE -> IDLE unconditionally on the next edge.
- Output timing:
  - done is 1 exactly while state==DONE.
  - ready = (state==IDLE); busy = (state==SHIFT).
  - diff and bout change only on entry to DONE and hold until the next completion or reset.
- Latency:
  - Start accepted at edge k; done high in the cycle following edge k+WIDTH.
  - diff/bout are valid from that same cycle onward.
  - Minimum start-to-start spacing is WIDTH+2 edges (SHIFT xWIDTH, DONE, IDLE).
- start while busy or in DONE is ignored. No queuing; a, b and the running result are unaffected.
- a and b may change freely after the accepting edge.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - bout equals the borrow out of the MSB.
  - a==b gives diff=0, bout=0.
- Counter width: $clog2(WIDTH+1).
- WIDTH=1: a single SHIFT cycle.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default WIDTH constant.
- Single sub-module instance: the existing full_subtractor_b cell (ports a, b, bin, diff, bout) as the bit slice.
- All sequencing and registers live in serial_subtractor.

Test Plan:
- Basic subtraction, WIDTH=8: a=8'h5A, b=8'h23, start one cycle -> done pulses 8 edges after accept; diff=8'h37, bout=0; ready returns 1 on the following edge.
- Underflow: a=8'h10, b=8'h20 -> diff=8'hF0, bout=1.
- Edge cases:
  - a=8'h00, b=8'h00 -> diff=8'h00, bout=0.
  - a=8'hFF, b=8'h01 -> diff=8'hFE, bout=0.
  - a=8'h00, b=8'hFF -> diff=8'h01, bout=1.
- Start during busy: accept a=8'h05, b=8'h03; assert start with a=8'hFF, b=8'h00 mid-SHIFT -> ignored; result diff=8'h02, bout=0 with exactly one done pulse.
- Reset mid-op: drop rst_n at SHIFT cycle 4 -> diff=0, bout=0, done=0 immediately, ready=1 after release, no done pulse; the next op a=8'h80, b=8'h01 -> diff=8'h7F, bout=0.
- Back-to-back plus exhaustive check:
  - Issue start on every cycle ready=1 for all 256x256 pairs, or random pairs.
  - Compare against the golden model (a-b) mod 256 and a<b.
  - Check done is exactly one cycle wide and diff stays stable between completions.
